// File: rtl/fetch_unit_pkg.sv
// Shared fetch/controller definitions: nPC_sel codes,
// fetch FSM state type and the default reset PC.
package fetch_unit_pkg;

  localparam logic [1:0] NPC_PLUS4 = 2'b00;
  localparam logic [1:0] NPC_J     = 2'b01;
  localparam logic [1:0] NPC_BEQ   = 2'b10;
  localparam logic [1:0] NPC_JR    = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2
  } fstate_e;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection for fetch_unit.
// Low address bits are cleared unless IFU_ADDR_CHECK_EN.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] imm26,
  input  logic [1:0]  nPC_sel,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4
);

  logic [31:0] boff;
  logic [31:0] raw;

  assign pc_plus4 = pc + 32'd4;
  assign boff = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  always_comb begin
    raw = pc_plus4;
    unique case (nPC_sel)
      NPC_PLUS4: raw = pc_plus4;
      NPC_J:     raw = {pc_plus4[31:28], imm26, 2'b00};
      NPC_BEQ:   raw = zero ? pc_plus4 + boff : pc_plus4;
      NPC_JR:    raw = jr_target;
      default:   raw = pc_plus4;
    endcase
  end

`ifdef IFU_ADDR_CHECK_EN
  assign npc = raw;
`else
  assign npc = raw & ~32'h3;
`endif

endmodule

// File: rtl/fetch_unit.sv
// PC, fetch FSM, fetch buffer and IR.
// IFU_ADDR_CHECK_EN adds the sticky addr_err flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [1:0]  nPC_sel,
  input  logic        zero,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instruction,
  output logic        instr_valid
`ifdef IFU_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  fstate_e     state, state_d;
  logic        stale, stale_d;
  logic        load_buf, issue;
  logic        blk;
  logic [31:0] npc, pc_d;
  logic [31:0] fbuf, req_addr, ir;

  npc_calc u_npc (
    .pc        (pc),
    .imm26     (ir[25:0]),
    .nPC_sel   (nPC_sel),
    .zero      (zero),
    .jr_target (jr_target),
    .npc       (npc),
    .pc_plus4  (pc_plus4)
  );

  assign pc_d = PCWr ? npc : pc;

`ifdef IFU_ADDR_CHECK_EN
  logic err_d;
  assign err_d = addr_err | (PCWr & (|npc[1:0]));
  assign blk = err_d;
`else
  assign blk = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    stale_d  = stale;
    load_buf = 1'b0;
    issue    = 1'b0;
    unique case (state)
      F_IDLE: begin
        if (!blk) begin
          state_d = F_REQ;
          issue   = 1'b1;
        end
      end
      F_REQ: begin
        if (imem_ack) begin
          // data for an abandoned pc: drop and reissue
          if (stale || PCWr) begin
            stale_d = 1'b0;
            state_d = blk ? F_IDLE : F_REQ;
            issue   = !blk;
          end else begin
            load_buf = 1'b1;
            state_d  = F_FULL;
          end
        end else if (PCWr) begin
          stale_d = 1'b1;
        end
      end
      F_FULL: begin
        if (PCWr) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      state    <= F_IDLE;
      stale    <= 1'b0;
      fbuf     <= 32'd0;
      req_addr <= RESET_PC;
      ir       <= 32'd0;
    end else begin
      if (PCWr) pc <= npc;
      state <= state_d;
      stale <= stale_d;
      if (load_buf) fbuf <= imem_rdata;
      if (issue) req_addr <= pc_d;
      if (IRWr && instr_valid) ir <= fbuf;
    end
  end

`ifdef IFU_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err <= 1'b0;
    else      addr_err <= err_d;
  end
`endif

  assign imem_req    = (state == F_REQ);
  assign imem_addr   = req_addr;
  assign instr_valid = (state == F_FULL);
  assign instruction = ir;

endmodule
